// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 receive path.
// Optional feature macro used by the top level: RS422_RX_FRAME_ERR_EN.
package rs422_pkg;

    localparam int RS422_BYTE_W   = 8;
    localparam int RS422_SYNC_DEF = 2;

    typedef struct packed {
        logic                    last;
        logic [RS422_BYTE_W-1:0] data;
    } rs422_entry_t;

endpackage

// File: rtl/rs422_rx_to_axistream_if.sv
// 8-bit AXI-Stream link carrying received bytes.
// Handshake: a beat transfers on a clk edge where tvalid && tready; while tvalid is high and tready low, tdata/tlast hold.
interface rs422_rx_to_axistream_if;
    import rs422_pkg::*;

    logic                    tvalid;
    logic                    tready;
    logic [RS422_BYTE_W-1:0] tdata;
    logic                    tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/rs422_rx_fifo.sv
// First-word fall-through FIFO of {last,data} entries; head is visible while not empty.
// Pointers carry one extra MSB so full and empty are distinguishable without a counter.
module rs422_rx_fifo
    import rs422_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  rs422_entry_t din,
    output logic         full,
    input  logic         pop,
    output rs422_entry_t dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    rs422_entry_t  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Head forced to zero when empty so the bus reads zero out of reset.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rs422_rx_to_axistream.sv
// RS422 3-wire receiver: synchronises the line, deserialises MSB-first bytes, streams them out as AXIS with tlast per frame.
// Define RS422_RX_FRAME_ERR_EN to add the frame_err pulse output.
module rs422_rx_to_axistream
    import rs422_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = RS422_SYNC_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic rs422_clk,
    input  logic rs422_cs,
    input  logic rs422_data,
    rs422_rx_to_axistream_if.master axis,
`ifdef RS422_RX_FRAME_ERR_EN
    output logic frame_err,
`endif
    output logic overflow
);

    logic [SYNC_STAGES-1:0]  clk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  data_sync;
    logic [SYNC_STAGES-1:0]  fill;
    logic                    clk_prev;
    logic                    cs_prev;
    logic                    clk_s;
    logic                    cs_s;
    logic                    data_s;
    logic                    sync_ok;
    logic                    clk_rise;
    logic                    cs_rise;
    logic                    sample;
    logic                    byte_done;
    logic [RS422_BYTE_W-1:0] new_byte;

    logic [RS422_BYTE_W-2:0] shreg;
    logic [2:0]              bit_cnt;
    logic                    held_valid;
    logic [RS422_BYTE_W-1:0] held_data;
    logic                    armed;
    logic                    push_q;
    rs422_entry_t            push_entry;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    rs422_entry_t            head;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // fill marks when the synchroniser holds real line values rather than reset values,
    // so a frame already running at reset release never looks like an idle-high cs.
    assign sync_ok   = fill[SYNC_STAGES-1];
    assign clk_rise  = sync_ok && clk_s && !clk_prev;
    assign cs_rise   = sync_ok && cs_s && !cs_prev;
    assign sample    = clk_rise && !cs_s && armed;
    assign byte_done = sample && (bit_cnt == 3'd7);
    assign new_byte  = {shreg, data_s};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync  <= '1;
            cs_sync   <= '1;
            data_sync <= '0;
            fill      <= '0;
            clk_prev  <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], rs422_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], rs422_cs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], rs422_data};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            clk_prev  <= clk_s;
            cs_prev   <= cs_s;
        end
    end

    // A completed byte is held back one byte so the last one of a frame can be tagged at cs rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            held_valid <= 1'b0;
            held_data  <= '0;
            armed      <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
            overflow   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (sync_ok && cs_s) armed <= 1'b1;
            if (sample) begin
                shreg   <= new_byte[RS422_BYTE_W-2:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    if (held_valid) begin
                        push_q     <= 1'b1;
                        push_entry <= '{last: 1'b0, data: held_data};
                    end
                    held_data  <= new_byte;
                    held_valid <= 1'b1;
                end
            end else if (cs_rise) begin
                if (held_valid) begin
                    push_q     <= 1'b1;
                    push_entry <= '{last: 1'b1, data: held_data};
                end
                held_valid <= 1'b0;
                bit_cnt    <= '0;
                shreg      <= '0;
            end
            overflow <= push_q && fifo_full && !pop;
        end
    end

`ifdef RS422_RX_FRAME_ERR_EN
    logic stray;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stray     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= cs_rise && ((bit_cnt != 3'd0) || (!armed && stray));
            if (cs_rise) begin
                stray <= 1'b0;
            end else if (clk_rise && !cs_s && !armed) begin
                stray <= 1'b1;
            end
        end
    end
`endif

    rs422_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_q),
        .din   (push_entry),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty)
    );

    assign pop         = axis.tvalid && axis.tready;
    assign axis.tvalid = !fifo_empty;
    assign axis.tdata  = head.data;
    assign axis.tlast  = head.last;

endmodule

// File: tb/tb_rs422_rx_to_axistream.sv
// Bench for rs422_rx_to_axistream: drives RS422 frames, models expected beats as a per-frame byte list.
module tb_rs422_rx_to_axistream;
  import rs422_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rs422_clk = 1'b1;
  logic rs422_cs = 1'b1;
  logic rs422_data = 1'b0;
  logic overflow;
`ifdef RS422_RX_FRAME_ERR_EN
  logic frame_err;
  int fe_cnt = 0;
`endif

  rs422_rx_to_axistream_if axis ();

  rs422_rx_to_axistream dut (
    .clk        (clk),
    .rstn       (rstn),
    .rs422_clk  (rs422_clk),
    .rs422_cs   (rs422_cs),
    .rs422_data (rs422_data),
    .axis       (axis),
`ifdef RS422_RX_FRAME_ERR_EN
    .frame_err  (frame_err),
`endif
    .overflow   (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] fb[32];
  int ovf_cnt = 0;
  int tready_mode = 0;
  logic stall_q = 1'b0;
  logic [8:0] stall_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- tready driver ----------------
  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: axis.tready = 1'b1;
        1: axis.tready = 1'($urandom_range(0, 1));
        2: axis.tready = 1'b0;
        default: axis.tready = ~axis.tready;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
`ifdef RS422_RX_FRAME_ERR_EN
      if (frame_err) fe_cnt++;
`endif
      if (stall_q) begin
        check("stall_tvalid", 32'(axis.tvalid), 32'd1);
        check("stall_beat", 32'({axis.tlast, axis.tdata}), 32'(stall_val));
      end
      if (axis.tvalid && axis.tready) begin
        got_q.push_back({axis.tlast, axis.tdata});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", {axis.tlast, axis.tdata}, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({axis.tlast, axis.tdata}), 32'(e));
        end
      end
      stall_q = axis.tvalid && !axis.tready;
      stall_val = {axis.tlast, axis.tdata};
    end
  end

  // ---------------- reference model ----------------
  // A frame yields one beat per complete byte; the final one carries last; trailing bits vanish.
  task automatic expect_frame(input int nb, input int keep);
    for (int i = 0; i < nb && i < keep; i++) exp_q.push_back({(i == nb - 1), fb[i]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rs422_data = v;
    rs422_clk = 1'b0;
    wait_clks(2);
    rs422_clk = 1'b1;
    wait_clks(2);
  endtask

  task automatic send_frame(input int nb, input int extra);
    rs422_cs = 1'b0;
    wait_clks(2);
    for (int i = 0; i < nb; i++)
      for (int b = 7; b >= 0; b--) send_bit(fb[i][b]);
    for (int x = 0; x < extra; x++) send_bit(1'($urandom_range(0, 1)));
    wait_clks(2);
    rs422_cs = 1'b1;
    wait_clks(6);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    wait_clks(8);
    check({name, "_idle_tvalid"}, 32'(axis.tvalid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tvalid"}, 32'(axis.tvalid), 32'd0);
    check({name, "_tdata"}, 32'(axis.tdata), 32'd0);
    check({name, "_tlast"}, 32'(axis.tlast), 32'd0);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nb, extra;
`ifdef RS422_RX_FRAME_ERR_EN
    int fe0;
`endif
    rstn = 1'b0;
    wait_clks(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    wait_clks(6);

    // two-byte frame
    fb[0] = 8'hA5; fb[1] = 8'h3C;
    expect_frame(2, 99);
    check("model_a5", 32'(exp_q[0]), 32'h0A5);
    check("model_3c", 32'(exp_q[1]), 32'h13C);
    got_q.delete();
    send_frame(2, 0);
    wait_drain("a5_3c");
    check("a5_3c_count", 32'(got_q.size()), 32'd2);
    check("a5_3c_beat0", 32'(got_q[0]), 32'h0A5);
    check("a5_3c_beat1", 32'(got_q[1]), 32'h13C);
    check("a5_3c_ovf", 32'(ovf_cnt), 32'd0);

    // single byte frame, then an empty frame
    fb[0] = 8'h81;
    expect_frame(1, 99);
    check("model_81", 32'(exp_q[0]), 32'h181);
    send_frame(1, 0);
    wait_drain("one_byte");
    got_q.delete();
    send_frame(0, 0);
    wait_drain("empty_frame");
    check("empty_frame_beats", 32'(got_q.size()), 32'd0);

    // partial trailing bits
    fb[0] = 8'hFF; fb[1] = 8'h00;
    expect_frame(2, 99);
    check("model_ff", 32'(exp_q[0]), 32'h0FF);
    check("model_00", 32'(exp_q[1]), 32'h100);
`ifdef RS422_RX_FRAME_ERR_EN
    fe0 = fe_cnt;
`endif
    send_frame(2, 3);
    wait_drain("partial");
`ifdef RS422_RX_FRAME_ERR_EN
    check("partial_frame_err", 32'(fe_cnt - fe0), 32'd1);
`endif

    // overflow: 20 bytes into a 16-deep FIFO with the sink stalled
    tready_mode = 2;
    wait_clks(2);
    ovf_cnt = 0;
    for (int i = 0; i < 20; i++) fb[i] = 8'(i + 1);
    expect_frame(20, 16);
    check("model_ovf_first", 32'(exp_q[0]), 32'h001);
    check("model_ovf_last", 32'(exp_q[15]), 32'h010);
    send_frame(20, 0);
    wait_clks(10);
    check("ovf_pulses", 32'(ovf_cnt), 32'd4);
    ovf_cnt = 0;
    tready_mode = 0;
    wait_drain("ovf_drain");

    // toggling ready
    tready_mode = 3;
    for (int i = 0; i < 4; i++) fb[i] = 8'($urandom_range(0, 255));
    expect_frame(4, 99);
    send_frame(4, 0);
    wait_drain("toggle");
    tready_mode = 0;

    // reset in the middle of byte 2
    fb[0] = 8'($urandom_range(0, 255)); fb[1] = 8'($urandom_range(0, 255));
    rs422_cs = 1'b0;
    wait_clks(2);
    for (int b = 7; b >= 0; b--) send_bit(fb[0][b]);
    for (int b = 7; b >= 4; b--) send_bit(fb[1][b]);
    rstn = 1'b0;
    wait_clks(3);
    check_reset_outputs("midreset");
    exp_q.delete();
    rstn = 1'b1;
    for (int b = 3; b >= 0; b--) send_bit(fb[1][b]);
    wait_clks(2);
    rs422_cs = 1'b1;
    wait_clks(6);
    wait_drain("aborted");
    fb[0] = 8'h55;
    expect_frame(1, 99);
    check("model_55", 32'(exp_q[0]), 32'h155);
    send_frame(1, 0);
    wait_drain("after_reset");

    // randomized frames with random ready
    for (int k = 0; k < 8; k++) begin
      tready_mode = 1;
      nb = $urandom_range(0, 4);
      extra = $urandom_range(0, 7);
      for (int i = 0; i < nb; i++) fb[i] = 8'($urandom_range(0, 255));
      expect_frame(nb, 99);
      send_frame(nb, extra);
      wait_drain("random");
    end
    tready_mode = 0;
    check("no_spurious_ovf", 32'(ovf_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
